opt_pipe_sequencer: RTL and testbench
=====================================

# opt_pipe_sequencer

Self-checking sequencer for the two-stage XOR/ADD operand pipeline used in synthesis-optimisation experiments on the Nexys4 DDR board. On a start pulse it generates a deterministic stream of operand pairs and pushes them through an internal stage-0/stage-1 pipeline whose two operations cancel. It checks every result against the delayed original operand and reports an error count, the first failing vector and a pass flag. It sits between the board I/O (button, switches, LEDs) and the pipeline under test, replacing manual switch stimulus.

## Interface
- NUM_VEC, default 256: vectors per run; legal range 1..65535.
- SEED, default 8'hA5: LFSR seed; a value of 0 is replaced by 8'h01.
- CLK100MHZ  in  1  single clock; all logic on its rising edge.
- CPU_RESETN  in  1  reset, synchronous and active-low.
- start  in  1  single-cycle start pulse, already synchronised.
- mode  in  1  pipeline operation: 0 = XOR/XOR, 1 = ADD/SUB; sampled only on the accepted start.
- err_inject  in  1  when 1 at issue, flips bit 0 of that vector's stage-1 result.
- busy  out  1  1 in RUN and DRAIN.
- done  out  1  1 in DONE.
- pass  out  1  done & (err_cnt == 0).
- err_cnt  out  8  mismatch count, saturating at 255.
- first_fail  out  16  index of the first mismatching vector; 16'hFFFF if none.
- last_result  out  8  most recent stage-1 result; for the LEDs.

## Operation
- States and transitions:
  - IDLE → RUN on start.
  - RUN → DRAIN on the edge that issues vector NUM_VEC-1.
  - DRAIN → DONE on the edge where the last vector is compared.
  - DONE → RUN on start.
- Start is ignored in RUN and DRAIN.
- Accepting start (from IDLE or DONE), on the same edge:
  - latch mode;
  - reload the LFSR with SEED;
  - clear the issue index, err_cnt, last_result and the pipeline valids;
  - set first_fail to 16'hFFFF.
- Operand generation:
  - a = current LFSR value.
  - b = {a[3:0], a[7:4]} ^ idx[7:0].
  - LFSR: 8-bit Galois, taps 8'hB8, right shift, advances once per issued vector. The sequence is 8'hA5, 8'hEA, 8'h75, ... for the default seed.
- Stage 0 (load, one per cycle in RUN): st0_d = a ^ b (mode 0) or a + b mod 256 (mode 1). Also register a, b, idx, err_inject and st0_valid = 1.
- Stage 1: st1_d = st0_d ^ b (mode 0) or st0_d - b mod 256 (mode 1), with bit 0 inverted if that vector's err_inject is set. Carry a, idx and valid forward.
- Compare, when st1_valid:
  - if st1_d != a: err_cnt increments unless already 255;
  - if st1_d != a and first_fail == 16'hFFFF: first_fail = idx;
  - last_result = st1_d.
- All arithmetic is 8-bit unsigned; carries and borrows are discarded.

## Timing
- Reset values: state IDLE; busy 0; done 0; pass 0; err_cnt 0; first_fail 16'hFFFF; last_result 0; all valids 0; LFSR = SEED.
- Reset asserted mid-run forces the reset values on the next edge. No partial results are kept.
- Pipeline schedule, with start sampled at edge S:
  - state becomes RUN after S;
  - vector k loads stage 0 at edge S+1+k, stage 1 at S+2+k, and is compared at S+3+k;
  - the RUN → DRAIN transition coincides with loading vector NUM_VEC-1 at edge S+NUM_VEC.
- done, final err_cnt, first_fail and last_result all become valid after edge S+NUM_VEC+2. busy falls on that same edge.
- Throughput: one vector per cycle, with no bubbles.
- Start in DONE: done drops and busy rises on the accepting edge.
- err_inject and mode changes during a run affect only the err_inject of vectors issued afterwards. The latched mode stays fixed for the run.

## Test plan
- Reset: hold CPU_RESETN=0 for 3 cycles → all outputs at their reset values; start while reset is asserted is ignored.
- NUM_VEC=16, mode=0, err_inject=0, start at edge S → busy high for 18 cycles, done after S+18, err_cnt=0, pass=1, first_fail=16'hFFFF.
- Same as above with mode=1 → err_cnt=0, pass=1. last_result equals the vector-15 operand a from the reference LFSR model.
- NUM_VEC=16, err_inject held at 1 → err_cnt=16, first_fail=0, pass=0. err_inject pulsed only when vector 5 issues → err_cnt=1, first_fail=5.
- NUM_VEC=300, err_inject=1 → err_cnt saturates at 255, done after S+302.
- Start pulsed mid-RUN → ignored, with identical results. Reset asserted at vector 7 → IDLE with reset values; a subsequent start gives a clean full run.

Source files
------------

// File: rtl/opt_pipe_sequencer.sv
// Deterministic operand sequencer driving a two-stage cancelling XOR/ADD pipeline,
// checking each result against the delayed operand and reporting errors.
module opt_pipe_sequencer #(
  parameter int unsigned NUM_VEC = 256,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        start,
  input  logic        mode,
  input  logic        err_inject,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_cnt,
  output logic [15:0] first_fail,
  output logic [7:0]  last_result
);

  localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state;
  logic        run_mode;
  logic [7:0]  lfsr;
  logic [15:0] idx;

  logic        st0_valid, st0_err;
  logic [7:0]  st0_d, st0_a, st0_b;
  logic [15:0] st0_idx;
  logic        st1_valid;
  logic [7:0]  st1_d, st1_a;
  logic [15:0] st1_idx;

  logic [7:0]  op_a, op_b, lfsr_next, st0_calc, st1_calc, err_next;
  logic        mismatch, accept;

  always_comb begin
    op_a      = lfsr;
    op_b      = {lfsr[3:0], lfsr[7:4]} ^ idx[7:0];
    lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 8'hB8 : 8'h00);
    st0_calc  = run_mode ? (op_a + op_b) : (op_a ^ op_b);
    st1_calc  = (run_mode ? (st0_d - st0_b) : (st0_d ^ st0_b)) ^ {7'b0, st0_err};
    mismatch  = st1_valid && (st1_d != st1_a);
    err_next  = (mismatch && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
    accept    = start && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state       <= IDLE;
      run_mode    <= 1'b0;
      lfsr        <= SEED_EFF;
      idx         <= '0;
      st0_valid   <= 1'b0;
      st0_err     <= 1'b0;
      st0_d       <= '0;
      st0_a       <= '0;
      st0_b       <= '0;
      st0_idx     <= '0;
      st1_valid   <= 1'b0;
      st1_d       <= '0;
      st1_a       <= '0;
      st1_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_cnt     <= '0;
      first_fail  <= '1;
      last_result <= '0;
    end else if (accept) begin
      state       <= RUN;
      run_mode    <= mode;
      lfsr        <= SEED_EFF;
      idx         <= '0;
      st0_valid   <= 1'b0;
      st1_valid   <= 1'b0;
      err_cnt     <= '0;
      first_fail  <= '1;
      last_result <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      // Stage 0 loads one vector per RUN cycle; stage 1 and compare always advance.
      st0_valid <= (state == RUN);
      if (state == RUN) begin
        st0_d   <= st0_calc;
        st0_a   <= op_a;
        st0_b   <= op_b;
        st0_idx <= idx;
        st0_err <= err_inject;
        lfsr    <= lfsr_next;
        idx     <= idx + 16'd1;
        if (idx == LAST_IDX) state <= DRAIN;
      end
      st1_valid <= st0_valid;
      st1_d     <= st1_calc;
      st1_a     <= st0_a;
      st1_idx   <= st0_idx;
      if (st1_valid) begin
        err_cnt     <= err_next;
        last_result <= st1_d;
        if (mismatch && (first_fail == 16'hFFFF)) first_fail <= st1_idx;
      end
      // Last compare happens when stage 1 is valid with nothing left behind it.
      if ((state == DRAIN) && st1_valid && !st0_valid) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= (err_next == 8'h00);
      end
    end
  end

endmodule

// File: tb/tb_opt_pipe_sequencer.sv
// Scoreboard bench: run expectations are queued at start, a monitor compares on done.
module tb_opt_pipe_sequencer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start16 = 1'b0, start300 = 1'b0, mode = 1'b0, inj = 1'b0;
  logic busy16, done16, pass16, busy300, done300, pass300;
  logic [7:0]  err16, last16, err300, last300;
  logic [15:0] ff16, ff300;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  opt_pipe_sequencer #(.NUM_VEC(16), .SEED(8'hA5)) dut16 (
    .CLK100MHZ(clk), .CPU_RESETN(rstn), .start(start16), .mode(mode), .err_inject(inj),
    .busy(busy16), .done(done16), .pass(pass16), .err_cnt(err16),
    .first_fail(ff16), .last_result(last16));

  opt_pipe_sequencer #(.NUM_VEC(300), .SEED(8'h00)) dut300 (
    .CLK100MHZ(clk), .CPU_RESETN(rstn), .start(start300), .mode(mode), .err_inject(inj),
    .busy(busy300), .done(done300), .pass(pass300), .err_cnt(err300),
    .first_fail(ff300), .last_result(last300));

  typedef struct {
    bit          big;
    int          nv;
    logic [7:0]  err;
    logic [15:0] ff;
    logic        pass;
    logic [7:0]  last;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, got, req);
  endtask

  // Reference: pipeline cancels, so each result is operand a, bit 0 flipped if injected.
  // kind: 0 no injection, 1 every vector, 2 vector 5 only.
  task automatic push_exp(input bit big, input int nv, input int kind, input logic [7:0] seed,
                          input int s);
    exp_t e;
    logic [7:0] l;
    int cnt;
    bit hit;
    l = seed; cnt = 0;
    e.big = big; e.nv = nv; e.ff = 16'hFFFF; e.last = 8'h00;
    for (int k = 0; k < nv; k++) begin
      hit = (kind == 1) || (kind == 2 && k == 5);
      if (hit) begin
        cnt++;
        if (e.ff == 16'hFFFF) e.ff = 16'(k);
      end
      e.last = l ^ {7'b0, hit};
      l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
    end
    e.err = (cnt > 255) ? 8'hFF : 8'(cnt);
    e.pass = (cnt == 0);
    e.done_cyc = s + nv + 2;
    exp_q.push_back(e);
  endtask

  // Returns on the falling edge after the accepting edge S (cyc == S there).
  task automatic start_run(input bit big, input int nv, input int kind, input bit push);
    @(negedge clk);
    if (big) start300 = 1'b1; else start16 = 1'b1;
    if (push) push_exp(big, nv, kind, big ? 8'h01 : 8'hA5, cyc + 1);
    @(negedge clk);
    start16 = 1'b0;
    start300 = 1'b0;
  endtask

  task automatic wait_done(input bit big, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = big ? done300 : done16;
    end
    check("done_timeout", {31'b0, seen}, 32'd1);
  endtask

  task automatic check_reset16(input string tag);
    check({tag, "_busy"}, {31'b0, busy16}, 32'd0);
    check({tag, "_done"}, {31'b0, done16}, 32'd0);
    check({tag, "_pass"}, {31'b0, pass16}, 32'd0);
    check({tag, "_err"}, {24'b0, err16}, 32'd0);
    check({tag, "_ff"}, {16'b0, ff16}, 32'hFFFF);
    check({tag, "_last"}, {24'b0, last16}, 32'd0);
  endtask

  // Monitor: on every rising done, pop the oldest expectation and compare.
  int busy_cyc = 0;
  logic pd16 = 1'b0, pd300 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    bit sel;
    if (!rstn) busy_cyc = 0;
    else if (busy16 || busy300) busy_cyc++;
    if ((done16 && !pd16) || (done300 && !pd300)) begin
      sel = done300 && !pd300;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("dut_select", {31'b0, sel}, {31'b0, e.big});
        check("done_cycle", cyc, e.done_cyc);
        check("busy_cycles", busy_cyc, e.nv + 2);
        check("err_cnt", {24'b0, sel ? err300 : err16}, {24'b0, e.err});
        check("first_fail", {16'b0, sel ? ff300 : ff16}, {16'b0, e.ff});
        check("pass", {31'b0, sel ? pass300 : pass16}, {31'b0, e.pass});
        check("last_result", {24'b0, sel ? last300 : last16}, {24'b0, e.last});
      end
      busy_cyc = 0;
    end
    pd16 = done16;
    pd300 = done300;
  end

  initial begin
    // Reset held 3 cycles with start asserted: start must be ignored.
    start16 = 1'b1; start300 = 1'b1;
    repeat (3) @(negedge clk);
    check_reset16("rst");
    check("rst300_err", {24'b0, err300}, 32'd0);
    check("rst300_ff", {16'b0, ff300}, 32'hFFFF);
    start16 = 1'b0; start300 = 1'b0; rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy16", {31'b0, busy16}, 32'd0);
    check("idle_busy300", {31'b0, busy300}, 32'd0);

    // Mode 0, clean run.
    mode = 1'b0; inj = 1'b0;
    start_run(1'b0, 16, 0, 1'b1);
    wait_done(1'b0, 100);

    // Mode 1 from DONE; early results are the seed sequence A5, EA, 75.
    mode = 1'b1;
    start_run(1'b0, 16, 0, 1'b1);
    check("restart_done", {31'b0, done16}, 32'd0);
    check("restart_busy", {31'b0, busy16}, 32'd1);
    repeat (3) @(negedge clk);
    check("v0_result", {24'b0, last16}, 32'hA5);
    @(negedge clk);
    check("v1_result", {24'b0, last16}, 32'hEA);
    @(negedge clk);
    check("v2_result", {24'b0, last16}, 32'h75);
    wait_done(1'b0, 100);

    // Error injection on every vector.
    mode = 1'b0; inj = 1'b1;
    start_run(1'b0, 16, 1, 1'b1);
    wait_done(1'b0, 100);
    inj = 1'b0;

    // Error injection only while vector 5 issues (edge S+6).
    start_run(1'b0, 16, 2, 1'b1);
    repeat (5) @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    wait_done(1'b0, 100);

    // Start pulse and mode change mid-run must not disturb the run.
    mode = 1'b1;
    start_run(1'b0, 16, 0, 1'b1);
    repeat (4) @(negedge clk);
    start16 = 1'b1; mode = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    wait_done(1'b0, 100);

    // Reset applied on the edge that would load vector 7.
    start_run(1'b0, 16, 0, 1'b0);
    repeat (7) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset16("midrst");
    rstn = 1'b1;
    @(negedge clk);
    start_run(1'b0, 16, 0, 1'b1);
    wait_done(1'b0, 100);

    // 300 vectors, zero seed, injection everywhere: err_cnt saturates.
    inj = 1'b1;
    start_run(1'b1, 300, 1, 1'b1);
    wait_done(1'b1, 400);
    inj = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
